// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, with a saturating drain counter.
// Define ROTATE_EN to enable circular shifts through the rotate input; otherwise rotate is ignored.
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter int                 CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] datain,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             rotate,
  output logic [WIDTH-1:0] dataout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic rot;

`ifdef ROTATE_EN
  assign rot = rotate;
`else
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign rot = 1'b0;
`endif

  // Rotations keep every bit inside the register, so they never advance the drain count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout   <= RESET_VAL;
      shift_cnt <= CNT_FULL;
    end else if (en) begin
      case (mode)
        2'b00: begin
          dataout   <= dataout;
          shift_cnt <= shift_cnt;
        end
        2'b01: begin
          if (rot) begin
            dataout <= {dataout[0], dataout[WIDTH-1:1]};
          end else begin
            dataout <= {sin_r, dataout[WIDTH-1:1]};
            if (shift_cnt != CNT_FULL) shift_cnt <= shift_cnt + CW'(1);
          end
        end
        2'b10: begin
          if (rot) begin
            dataout <= {dataout[WIDTH-2:0], dataout[WIDTH-1]};
          end else begin
            dataout <= {dataout[WIDTH-2:0], sin_l};
            if (shift_cnt != CNT_FULL) shift_cnt <= shift_cnt + CW'(1);
          end
        end
        2'b11: begin
          dataout   <= datain;
          shift_cnt <= '0;
        end
      endcase
    end
  end

  assign sout_r  = dataout[0];
  assign sout_l  = dataout[WIDTH-1];
  assign drained = (shift_cnt == CNT_FULL);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): driver pushes expected state, monitor pops and compares.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] datain = '0;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;
  logic         rotate = 1'b0;
  logic [W-1:0] dataout;
  logic         sout_r;
  logic         sout_l;
  logic [3:0]   shift_cnt;
  logic         drained;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .datain(datain),
    .sin_r(sin_r), .sin_l(sin_l), .rotate(rotate), .dataout(dataout),
    .sout_r(sout_r), .sout_l(sout_l), .shift_cnt(shift_cnt), .drained(drained)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // packed expectation: {drained, shift_cnt[3:0], sout_l, sout_r, dataout[7:0]}
  logic [14:0] exp_q[$];
  string       name_q[$];
  event        obs_ev;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [14:0] pk(input logic [7:0] d, input logic [3:0] c, input logic dr);
    return {dr, c, d[7], d[0], d};
  endfunction

  // scoreboard monitor
  initial begin
    logic [14:0] act, exp;
    string nm;
    forever begin
      @(obs_ev);
      act = {drained, shift_cnt, sout_l, sout_r, dataout};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: act data=%h cnt=%0d drained=%b, no expectation queued",
                 dataout, shift_cnt, drained);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL %s: act data=%h cnt=%0d dr=%b sl=%b sr=%b, exp data=%h cnt=%0d dr=%b sl=%b sr=%b",
                   nm, act[7:0], act[13:10], act[14], act[9], act[8],
                   exp[7:0], exp[13:10], exp[14], exp[9], exp[8]);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input logic e, input logic [1:0] m, input logic [7:0] din,
                      input logic sr, input logic sl, input logic rot,
                      input logic [7:0] ed, input logic [3:0] ec, input logic edr,
                      input string nm);
    @(negedge clk);
    en = e; mode = m; datain = din; sin_r = sr; sin_l = sl; rotate = rot;
    exp_q.push_back(pk(ed, ec, edr));
    name_q.push_back(nm);
    @(posedge clk);
    #1 -> obs_ev;
  endtask

  task automatic async_reset_check(input string nm);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(pk(8'h00, 4'd8, 1'b1));
    name_q.push_back(nm);
    -> obs_ev;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // expected register contents after k right shifts of 8'hA5 with sin_r=1
  logic [7:0] rs_tab [1:9] = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    async_reset_check("reset_async");
    // held reset must beat a load on a clock edge
    step(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 4'd8, 1'b1, "reset_overrides_load");
    release_reset();

    step(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0, "load_a5");
    for (int i = 0; i < 3; i++)
      step(1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0, "en_low_hold");
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h52, 4'd1, 1'b0, "shr_sin0");
    step(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd2, 1'b0, "shl_sin1");
    step(1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 4'd2, 1'b0, "mode00_hold");

    step(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0, "reload_a5");
    for (int k = 1; k <= 9; k++)
      step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, rs_tab[k],
           (k >= 8) ? 4'd8 : 4'(k), (k >= 8), $sformatf("drain_shr_%0d", k));
    step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE, 4'd8, 1'b1, "sat_shl");

    step(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0, "load_for_rot");
`ifdef ROTATE_EN
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 8'hD2, 4'd0, 1'b0, "rotr");
    step(1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd0, 1'b0, "rotl");
    step(1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1, 8'h4B, 4'd0, 1'b0, "rotl_wrap");
`else
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h52, 4'd1, 1'b0, "rot_ignored_shr");
    step(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd2, 1'b0, "rot_ignored_shl");
`endif

    step(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 4'd0, 1'b0, "load_3c");
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h1E, 4'd1, 1'b0, "shr3c_1");
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0F, 4'd2, 1'b0, "shr3c_2");
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h07, 4'd3, 1'b0, "shr3c_3");
    async_reset_check("reset_mid_shift");
    step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd8, 1'b1, "reset_overrides_shift");
    release_reset();
    step(1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0, "load_after_reset");
    step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hB4, 4'd1, 1'b0, "shl_sin0");

    #5;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
